// File: rtl/inst_issue_ctrl.sv
// Instruction queue and issue stage: a circular FIFO of (inst, pc) pairs feeding a registered decoder port.
// Optional macro ISSUE_BYPASS_EN lets a push into an empty queue load the output register directly.
module inst_issue_ctrl #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PTR_BITS     = 4,
    parameter int unsigned IDWidth      = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    if_issue_en_in,
    input  logic [IDWidth-1:0]      if_issue_inst_in,
    input  logic [AddressWidth-1:0] if_issue_pc_in,
    output logic                    issue_if_full_out,
    input  logic                    dispatcher_issue_stall_in,
    input  logic                    decoder_issue_rst_in,
    input  logic                    rob_issue_clear_in,
    output logic                    issue_decoder_en_out,
    output logic [IDWidth-1:0]      issue_decoder_inst_out,
    output logic [AddressWidth-1:0] issue_decoder_pc_out,
    output logic [PTR_BITS:0]       issue_count_out
);

    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(DEPTH);

    logic [IDWidth-1:0]      inst_mem [DEPTH];
    logic [AddressWidth-1:0] pc_mem   [DEPTH];

    logic [PTR_BITS-1:0]     head_q, head_d;
    logic [PTR_BITS-1:0]     tail_q, tail_d;
    logic [PTR_BITS:0]       count_q, count_d;
    logic                    en_q, en_d;
    logic [IDWidth-1:0]      inst_q, inst_d;
    logic [AddressWidth-1:0] pc_q, pc_d;

    logic flush, full, push_ok, pop, bypass, wr_en;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        en_d    = 1'b0;
        inst_d  = inst_q;
        pc_d    = pc_q;
        wr_en   = 1'b0;
        bypass  = 1'b0;

        flush   = decoder_issue_rst_in | rob_issue_clear_in;
        full    = (count_q == FULL_CNT);
        push_ok = if_issue_en_in & ~full & ~flush;
        pop     = (count_q != '0) & ~dispatcher_issue_stall_in & ~flush;
`ifdef ISSUE_BYPASS_EN
        bypass  = push_ok & (count_q == '0) & ~dispatcher_issue_stall_in;
`else
        bypass  = 1'b0;
`endif

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // pop and bypass are exclusive: bypass only fires on an empty queue
            if (pop) begin
                inst_d = inst_mem[head_q];
                pc_d   = pc_mem[head_q];
                en_d   = 1'b1;
                head_d = head_q + 1'b1;
            end else if (bypass) begin
                inst_d = if_issue_inst_in;
                pc_d   = if_issue_pc_in;
                en_d   = 1'b1;
            end

            wr_en = push_ok & ~bypass;
            if (wr_en) begin
                tail_d = tail_q + 1'b1;
            end

            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            en_q    <= en_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && wr_en) begin
            inst_mem[tail_q] <= if_issue_inst_in;
            pc_mem[tail_q]   <= if_issue_pc_in;
        end
    end

    assign issue_if_full_out      = (count_q == FULL_CNT);
    assign issue_decoder_en_out   = en_q;
    assign issue_decoder_inst_out = inst_q;
    assign issue_decoder_pc_out   = pc_q;
    assign issue_count_out        = count_q;

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Directed table-driven bench for inst_issue_ctrl in its default build (ISSUE_BYPASS_EN undefined).
module tb_inst_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        push = 1'b0;
    logic [31:0] inst_in = '0;
    logic [31:0] pc_in = '0;
    logic        full;
    logic        stall = 1'b0;
    logic        dec_rst = 1'b0;
    logic        rob_clr = 1'b0;
    logic        en;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [4:0]  cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_issue_ctrl #(.DEPTH(16), .PTR_BITS(4), .IDWidth(32), .AddressWidth(32)) dut (
        .clk_in                    (clk),
        .rst_in                    (rst),
        .rdy_in                    (rdy),
        .if_issue_en_in            (push),
        .if_issue_inst_in          (inst_in),
        .if_issue_pc_in            (pc_in),
        .issue_if_full_out         (full),
        .dispatcher_issue_stall_in (stall),
        .decoder_issue_rst_in      (dec_rst),
        .rob_issue_clear_in        (rob_clr),
        .issue_decoder_en_out      (en),
        .issue_decoder_inst_out    (inst_out),
        .issue_decoder_pc_out      (pc_out),
        .issue_count_out           (cnt)
    );

    typedef struct {
        bit          rst, rdy, push, stall, dec, rob;
        logic [31:0] pc, inst;
        bit          e_en;
        logic [31:0] e_pc, e_inst;
        int          e_cnt;
        bit          e_full;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] IA = 32'h0050_0093;
    localparam logic [31:0] IB = 32'h0010_0113;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    function automatic vec_t v(input bit r, input bit rd, input bit p, input logic [31:0] pc,
                               input logic [31:0] ins, input bit st, input bit d, input bit rb,
                               input bit e_en, input logic [31:0] e_pc, input logic [31:0] e_inst,
                               input int e_cnt);
        vec_t x;
        x.rst = r; x.rdy = rd; x.push = p; x.pc = pc; x.inst = ins;
        x.stall = st; x.dec = d; x.rob = rb;
        x.e_en = e_en; x.e_pc = e_pc; x.e_inst = e_inst; x.e_cnt = e_cnt;
        x.e_full = (e_cnt == 16);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit e_en, input logic [31:0] e_pc,
                           input logic [31:0] e_inst, input int e_cnt);
        chk({tag, " en"},   {31'b0, en}, {31'b0, e_en});
        chk({tag, " pc"},   pc_out, e_pc);
        chk({tag, " inst"}, inst_out, e_inst);
        chk({tag, " cnt"},  {27'b0, cnt}, 32'(e_cnt));
        chk({tag, " full"}, {31'b0, full}, {31'b0, (e_cnt == 16)});
    endtask

    task automatic drive(input bit r, input bit rd, input bit p, input logic [31:0] pc,
                         input bit st, input bit d, input bit rb);
        rst = r; rdy = rd; push = p; pc_in = pc; inst_in = mk(pc);
        stall = st; dec_rst = d; rob_clr = rb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hold_pc;

        // reset, idle, basic flow
        tbl.push_back(v(1,1,0,0,0,      0,0,0, 0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,      0,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,1,0,IA,     0,0,0, 0,0,0,1));
        tbl.push_back(v(0,1,1,4,IB,     0,0,0, 1,0,IA,1));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 1,4,IB,0));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 0,4,IB,0));
        // five queued under stall, then decoder flush with a simultaneous push
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0,1,1,32'h10+4*i,mk(32'h10+4*i), 1,0,0, 0,4,IB,i+1));
        tbl.push_back(v(0,1,1,32'h200,mk(32'h200), 0,1,0, 0,4,IB,0));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 0,4,IB,0));
        tbl.push_back(v(0,1,1,32'h300,mk(32'h300), 0,0,0, 0,4,IB,1));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 1,32'h300,mk(32'h300),0));
        // rob clear
        tbl.push_back(v(0,1,1,32'h310,mk(32'h310), 1,0,0, 0,32'h300,mk(32'h300),1));
        tbl.push_back(v(0,1,1,32'h314,mk(32'h314), 1,0,0, 0,32'h300,mk(32'h300),2));
        tbl.push_back(v(0,1,0,0,0,      0,0,1, 0,32'h300,mk(32'h300),0));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 0,32'h300,mk(32'h300),0));
        // flush while an instruction is presented
        tbl.push_back(v(0,1,1,32'h320,mk(32'h320), 0,0,0, 0,32'h300,mk(32'h300),1));
        tbl.push_back(v(0,1,1,32'h330,mk(32'h330), 0,0,0, 1,32'h320,mk(32'h320),1));
        tbl.push_back(v(0,1,0,0,0,      0,1,0, 0,32'h320,mk(32'h320),0));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 0,32'h320,mk(32'h320),0));
        // stall / rdy interleave with three queued
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,1,1,32'h400+4*i,mk(32'h400+4*i), 1,0,0, 0,32'h320,mk(32'h320),i+1));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 1,32'h400,mk(32'h400),2));
        tbl.push_back(v(0,1,0,0,0,      1,0,0, 0,32'h400,mk(32'h400),2));
        tbl.push_back(v(0,0,1,32'h4FC,mk(32'h4FC), 0,0,0, 0,32'h400,mk(32'h400),2));
        tbl.push_back(v(0,0,0,0,0,      0,0,0, 0,32'h400,mk(32'h400),2));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 1,32'h404,mk(32'h404),1));
        tbl.push_back(v(0,1,0,0,0,      1,0,0, 0,32'h404,mk(32'h404),1));
        tbl.push_back(v(0,1,0,0,0,      0,0,0, 1,32'h408,mk(32'h408),0));
        tbl.push_back(v(0,1,0,0,0,      1,0,0, 0,32'h408,mk(32'h408),0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; rdy = tbl[i].rdy; push = tbl[i].push;
            pc_in = tbl[i].pc; inst_in = tbl[i].inst; stall = tbl[i].stall;
            dec_rst = tbl[i].dec; rob_clr = tbl[i].rob;
            step();
            chk_all($sformatf("row%0d", i), tbl[i].e_en, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_cnt);
        end
        hold_pc = 32'h408;

        // full boundary: 17 pushes under stall, the last one dropped
        for (int i = 0; i < 17; i++) begin
            drive(0,1,1,32'(4*i),1,0,0);
            step();
            chk_all($sformatf("fill%0d", i), 0, hold_pc, mk(hold_pc), (i < 16) ? i + 1 : 16);
        end
        // push while full and popping is still dropped
        drive(0,1,1,32'hFFC,0,0,0);
        step();
        chk_all("drain0", 1, 32'h0, mk(32'h0), 15);
        for (int k = 1; k < 16; k++) begin
            drive(0,1,0,0,0,0,0);
            step();
            chk_all($sformatf("drain%0d", k), 1, 32'(4*k), mk(32'(4*k)), 15 - k);
        end
        step();
        chk_all("drain_end", 0, 32'h3C, mk(32'h3C), 0);

        // wrap-around
        for (int i = 0; i < 12; i++) begin
            drive(0,1,1,32'h50+32'(4*i),1,0,0);
            step();
            chk_all($sformatf("wfill%0d", i), 0, 32'h3C, mk(32'h3C), i + 1);
        end
        for (int i = 0; i < 12; i++) begin
            drive(0,1,0,0,0,0,0);
            step();
            chk_all($sformatf("wdrain%0d", i), 1, 32'h50+32'(4*i), mk(32'h50+32'(4*i)), 11 - i);
        end
        step();
        chk_all("wdrain_end", 0, 32'h7C, mk(32'h7C), 0);
        for (int i = 0; i < 10; i++) begin
            drive(0,1,1,32'h100+32'(4*i),0,0,0);
            step();
            if (i == 0) chk_all("wpush0", 0, 32'h7C, mk(32'h7C), 1);
            else chk_all($sformatf("wpush%0d", i), 1, 32'h100+32'(4*(i-1)),
                         mk(32'h100+32'(4*(i-1))), 1);
        end
        drive(0,1,0,0,0,0,0);
        step();
        chk_all("wlast", 1, 32'h124, mk(32'h124), 0);
        step();
        chk_all("wend", 0, 32'h124, mk(32'h124), 0);

        // reset with a non-empty queue and rdy low
        drive(0,1,1,32'h500,1,0,0);
        step();
        drive(0,1,1,32'h504,1,0,0);
        step();
        chk_all("pre_rst", 0, 32'h124, mk(32'h124), 2);
        drive(1,0,0,0,0,0,0);
        step();
        chk_all("rst_busy", 0, 0, 0, 0);
        drive(0,1,0,0,0,0,0);
        step();
        chk_all("post_rst", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_issue_ctrl.md
Name: inst_issue_ctrl

Overview:
- Instruction queue and issue sequencer between instruction fetch and the decoder.
- Buffers fetched (inst, pc) pairs in a circular FIFO and presents at most one instruction per cycle to the decoder through a registered output stage.
- Holds issue while the dispatcher stalls.
- Discards all queued work on a decoder redirect (JAL) or a ROB misprediction clear.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, at least 2.
- PTR_BITS, 4, log2(DEPTH); head/tail pointer width.
- IDWidth, 32, instruction word width.
- AddressWidth, 32, pc width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global ready; when low, all state is frozen.
- if_issue_en_in  input  1  fetch pushes one instruction this cycle.
- if_issue_inst_in  input  IDWidth  fetched instruction word.
- if_issue_pc_in  input  AddressWidth  pc of the fetched instruction.
- issue_if_full_out  output  1  queue full; fetch must not push.
- dispatcher_issue_stall_in  input  1  dispatcher cannot accept an instruction.
- decoder_issue_rst_in  input  1  decoder redirect (JAL); flush request.
- rob_issue_clear_in  input  1  misprediction clear; flush request.
- issue_decoder_en_out  output  1  valid instruction presented to decoder this cycle.
- issue_decoder_inst_out  output  IDWidth  presented instruction.
- issue_decoder_pc_out  output  AddressWidth  presented pc.
- issue_count_out  output  PTR_BITS+1  current number of queued entries (excludes output register).

Behaviour:
- Reset: only state updated at the rising edge with rst_in=1, and rst_in overrides rdy_in. Clears head, tail and count to 0. Drives issue_decoder_en_out=0, inst_out=0, pc_out=0, issue_if_full_out=0.
- rdy_in=0 with rst_in=0: no register changes; outputs hold their values.
- State is two pointers (head, tail) plus count. Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- issue_if_full_out = (count == DEPTH), derived from the registered count.
- Push: when if_issue_en_in=1 and full_out=0, write mem[tail] and advance tail.
  - A push while full_out=1 is dropped with no state change, even if a pop occurs in the same cycle.
- Pop condition: count>0 and dispatcher_issue_stall_in=0 and no flush this cycle.
  - On the edge, load output register from mem[head], set en_out=1, advance head.
  - Otherwise en_out=0 next cycle; inst_out and pc_out hold their last values.
- Each cycle with en_out=1 means exactly one instruction is consumed by the decoder/dispatcher. en_out is never held high for two cycles on the same instruction.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Latency (base): an instruction pushed in cycle t is earliest presented with en_out=1 in cycle t+2.
- Flush: decoder_issue_rst_in=1 or rob_issue_clear_in=1 at an edge (with rdy_in=1).
  - head=tail=0, count=0, en_out=0.
  - A push in the same cycle is discarded.
  - Flush takes priority over push, pop and stall.
  - The instruction presented during the flush cycle (e.g. the JAL itself) is considered consumed.
- Stall: the stall signal is sampled at the edge, so an instruction already presented (en_out=1) in the stall cycle is still consumed. No further pops occur while stall=1.
- Order is strictly FIFO; no reordering or duplication.

Optional Feature:
- Macro: ISSUE_BYPASS_EN.
- Defined: when count==0, a push is accepted, no stall and no flush, the incoming inst/pc load the output register directly with en_out=1 next cycle. The FIFO is not written and count is unchanged, giving 1-cycle latency.
- Not defined: every instruction passes through the FIFO, giving 2-cycle minimum latency.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles, then rst_in=0 with no push → en_out=0, count_out=0, full_out=0, inst_out=0, pc_out=0.
- Basic flow: push inst 0x00500093 / pc 0x0 in cycle 1, and 0x00100113 / 0x4 in cycle 2, with no stall.
  - Base build: en_out=1 in cycles 3 and 4, with pc 0x0 then 0x4.
  - With ISSUE_BYPASS_EN: the first instruction is presented in cycle 2.
- Full boundary: push 17 instructions back-to-back with stall=1 → full_out=1 after the 16th, 17th dropped, count_out=16. Release stall → 16 issues in consecutive cycles in pc order 0x0..0x3C.
- Wrap-around: push 12 entries, drain 12, then push 10 more (pcs 0x100..0x124) → pointers wrap, issue order 0x100..0x124, count returns to 0.
- Flush: queue holds 5 entries; assert decoder_issue_rst_in together with a push of pc 0x200 → next cycle count=0, en_out=0. The 0x200 instruction is never issued; a later push of pc 0x300 issues normally.
- Stall and rdy interaction: with 3 entries queued, alternate stall=1/0 each cycle and hold rdy_in=0 for 2 cycles mid-sequence.
  - en_out=1 only in cycles following stall=0 with rdy_in=1.
  - No duplicated or skipped pcs.
